// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM dimmer: register map, CTRL layout,
// reset values and the optional gamma helper (LED_PWM_GAMMA_EN).
package led_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL         = 2'd0;
  localparam logic [1:0] ADDR_BRIGHT       = 2'd1;
  localparam logic [1:0] ADDR_BLINK_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS       = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;

  typedef struct packed {
    logic blink_en;
    logic en;
  } ctrl_t;

  localparam ctrl_t      CTRL_RST   = '{blink_en: 1'b0, en: 1'b1};
  localparam logic [7:0] BRIGHT_RST = 8'hFF;

`ifdef LED_PWM_GAMMA_EN
  // Square-law brightness curve; full scale stays full scale so 255 is still "always on".
  function automatic logic [7:0] gamma8(input logic [7:0] d);
    logic [15:0] sq;
    sq = 16'(d) * 16'(d);
    return (d == 8'hFF) ? 8'hFF : sq[15:8];
  endfunction
`endif

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler producing one tick every PRESCALE clocks, an 8-bit
// PWM position counter advanced on each tick, and a strobe on the last tick
// of each 256-tick period.
module led_pwm_timebase #(
  parameter int PRESCALE = 195
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [7:0] pwm_cnt,
  output logic       period_end
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt;

  assign tick       = (presc_cnt == PRESC_MAX);
  assign period_end = tick && (pwm_cnt == 8'hFF);

  // Prescaler and PWM position counter; both restart from zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= 8'd0;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer: gates an 8-bit LED pattern with global PWM brightness and
// optional blinking. Configured through a 4-word Avalon-MM slave.
// Optional feature macro: LED_PWM_GAMMA_EN (square-law brightness curve).
//
// Bus handshake: Avalon-MM with no wait states. A write is accepted on every
// clk edge where avs_s0_write is high; readdata is combinational from the
// current register state while avs_s0_read is high and zero otherwise.
module led_pwm_dimmer
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE  = 195,
  parameter int BLINK_RST = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  output logic [31:0] avs_s0_readdata,
  input  logic [31:0] avs_s0_writedata,
  input  logic [7:0]  leds_in,
  output logic [7:0]  leds_out
);

  logic       tick;
  logic [7:0] pwm_cnt;
  logic       period_end;
  logic       boundary;

  ctrl_t       ctrl;
  logic [7:0]  duty_shadow;
  logic [7:0]  duty_cmp;
  logic        shadow_pending;
  logic [15:0] blink_period;
  logic [15:0] blink_cnt;
  logic        blink_phase;
  logic        pwm_on;
  logic        blink_off;

  logic wr_ctrl;
  logic wr_bright;
  logic wr_blink;

  led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );

  // The period strobe is only trusted when it coincides with a tick.
  assign boundary = period_end && tick;

  assign wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign wr_bright = avs_s0_write && (avs_s0_address == ADDR_BRIGHT);
  assign wr_blink  = avs_s0_write && (avs_s0_address == ADDR_BLINK_PERIOD);

  // Configuration registers and the shadow-pending flag; a BRIGHT write on a
  // boundary keeps the flag set so the new duty lands on the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl           <= CTRL_RST;
      duty_shadow    <= BRIGHT_RST;
      blink_period   <= 16'(BLINK_RST);
      shadow_pending <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl.en       <= avs_s0_writedata[CTRL_EN_BIT];
        ctrl.blink_en <= avs_s0_writedata[CTRL_BLINK_EN_BIT];
      end
      if (wr_bright) duty_shadow  <= avs_s0_writedata[7:0];
      if (wr_blink)  blink_period <= avs_s0_writedata[15:0];
      if (wr_bright)     shadow_pending <= 1'b1;
      else if (boundary) shadow_pending <= 1'b0;
    end
  end

`ifdef LED_PWM_GAMMA_EN
  // Compare threshold: gamma-corrected shadow duty, captured at the boundary.
  always_ff @(posedge clk) begin
    if (reset)         duty_cmp <= 8'hFF;
    else if (boundary) duty_cmp <= gamma8(duty_shadow);
  end
`else
  logic [7:0] duty_active;

  // Active duty: the shadow value is copied in only at a period boundary.
  always_ff @(posedge clk) begin
    if (reset)         duty_active <= BRIGHT_RST;
    else if (boundary) duty_active <= duty_shadow;
  end

  assign duty_cmp = duty_active;
`endif

  assign pwm_on    = (pwm_cnt < duty_cmp) || (duty_cmp == 8'hFF);
  assign blink_off = !ctrl.blink_en || (blink_period == 16'd0);

  // Blink half-period counter; phase parks at 1 whenever blinking is off.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (blink_off) begin
      blink_cnt   <= 16'd0;
      blink_phase <= 1'b1;
    end else if (wr_blink) begin
      blink_cnt <= 16'd0;
    end else if (boundary) begin
      if (blink_cnt == blink_period - 16'd1) begin
        blink_cnt   <= 16'd0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Registered output gating of the incoming pattern.
  always_ff @(posedge clk) begin
    if (reset) leds_out <= 8'd0;
    else       leds_out <= leds_in & {8{ctrl.en && pwm_on && blink_phase}};
  end

  // Combinational read mux; unused bits and idle cycles read as zero.
  always_comb begin
    avs_s0_readdata = 32'd0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_CTRL:         avs_s0_readdata = {30'd0, ctrl.blink_en, ctrl.en};
        ADDR_BRIGHT:       avs_s0_readdata = {24'd0, duty_shadow};
        ADDR_BLINK_PERIOD: avs_s0_readdata = {16'd0, blink_period};
        ADDR_STATUS:       avs_s0_readdata = {15'd0, shadow_pending, pwm_cnt, 7'd0, blink_phase};
        default:           avs_s0_readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Testbench for led_pwm_dimmer (PRESCALE=1 so one PWM period is 256 clocks).
module tb_led_pwm_dimmer;

  localparam int TB_PRESCALE  = 1;
  localparam int TB_BLINK_RST = 500;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_readdata;
  logic [31:0] avs_s0_writedata;
  logic [7:0]  leds_in;
  logic [7:0]  leds_out;

  always #5 clk = ~clk;

  led_pwm_dimmer #(.PRESCALE(TB_PRESCALE), .BLINK_RST(TB_BLINK_RST)) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_s0_address   (avs_s0_address),
    .avs_s0_read      (avs_s0_read),
    .avs_s0_write     (avs_s0_write),
    .avs_s0_readdata  (avs_s0_readdata),
    .avs_s0_writedata (avs_s0_writedata),
    .leds_in          (leds_in),
    .leds_out         (leds_out)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract state: timebase position, duties, flags, blink progress.
  int m_presc, m_pwm, m_act, m_sh, m_bper, m_bcnt;
  bit m_en, m_ben, m_pend, m_phase;
  logic [7:0] m_leds;

  function automatic int gamma_ref(input int d);
`ifdef LED_PWM_GAMMA_EN
    return (d == 255) ? 255 : (d * d) / 256;
`else
    return d;
`endif
  endfunction

  task automatic model_step();
    bit tk, pe, on, wr;
    int g;
    wr = avs_s0_write;
    if (reset) begin
      m_presc = 0; m_pwm = 0; m_act = 255; m_sh = 255; m_pend = 0;
      m_en = 1; m_ben = 0; m_bper = TB_BLINK_RST; m_bcnt = 0; m_phase = 1; m_leds = 8'h00;
      return;
    end
    tk = (m_presc == TB_PRESCALE - 1);
    pe = tk && (m_pwm == 255);
    g  = gamma_ref(m_act);
    on = (m_pwm < g) || (g == 255);
    m_leds = (m_en && on && m_phase) ? leds_in : 8'h00;
    if (!m_ben || m_bper == 0) begin
      m_bcnt = 0; m_phase = 1;
    end else if (wr && avs_s0_address == 2) begin
      m_bcnt = 0;
    end else if (pe) begin
      if (m_bcnt == m_bper - 1) begin m_bcnt = 0; m_phase = !m_phase; end
      else m_bcnt++;
    end
    if (pe) m_act = m_sh;
    if (wr && avs_s0_address == 1) m_pend = 1;
    else if (pe) m_pend = 0;
    if (wr) begin
      case (avs_s0_address)
        2'd0: begin m_en = avs_s0_writedata[0]; m_ben = avs_s0_writedata[1]; end
        2'd1: m_sh = avs_s0_writedata[7:0];
        2'd2: m_bper = avs_s0_writedata[15:0];
        default: ;
      endcase
    end
    m_presc = tk ? 0 : m_presc + 1;
    if (tk) m_pwm = (m_pwm + 1) % 256;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {30'd0, m_ben, m_en};
      2'd1: return 32'(m_sh);
      2'd2: return 32'(m_bper);
      default: return {15'd0, m_pend, 8'(m_pwm), 7'd0, m_phase};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    model_step();
    exp_q.push_back(m_leds);
    #1;
    e = exp_q.pop_front();
    check("leds_out", {24'd0, leds_out}, {24'd0, e});
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
    step();
    avs_s0_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_s0_address = a; avs_s0_read = 1'b1;
    #1;
    d = avs_s0_readdata;
    check("readdata", d, model_rd(a));
    avs_s0_read = 1'b0;
  endtask

  // Step until the next period boundary has applied any pending duty.
  task automatic align();
    int n = 0;
    while ((m_pwm != 0 || m_pend) && n < 1000) begin step(); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL align_timeout got=%0d expected<1000", n);
    end
  endtask

  task automatic count_on(input int n, output int on);
    on = 0;
    repeat (n) begin
      step();
      if (leds_out != 8'h00) on++;
    end
  endtask

  // ---------------- table-driven register vectors ----------------
  typedef struct {
    logic [1:0]  wr_addr;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    int on, n, toggles;
    logic prev;

    reset = 1'b1; avs_s0_address = 2'd0; avs_s0_read = 1'b0; avs_s0_write = 1'b0;
    avs_s0_writedata = 32'd0; leds_in = 8'hA5;

    vecs[0] = '{2'd0, 32'hFFFF_FFFD, 2'd0, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'h0000_0003, 2'd0, 32'h0000_0003};
    vecs[2] = '{2'd0, 32'h0000_0001, 2'd0, 32'h0000_0001};
    vecs[3] = '{2'd1, 32'hDEAD_BE40, 2'd1, 32'h0000_0040};
    vecs[4] = '{2'd1, 32'h0000_01FF, 2'd1, 32'h0000_00FF};
    vecs[5] = '{2'd2, 32'h000A_BCDE, 2'd2, 32'h0000_BCDE};
    vecs[6] = '{2'd2, 32'h0000_01F4, 2'd2, 32'h0000_01F4};
    vecs[7] = '{2'd3, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001};

    repeat (2) step();
    reset = 1'b0;

    // Reset release with defaults: pattern passes from the first edge.
    step();
    check("first_edge_leds", {24'd0, leds_out}, 32'h0000_00A5);
    bus_read(2'd0, rd); check("ctrl_rst", rd, 32'h1);
    bus_read(2'd1, rd); check("bright_rst", rd, 32'hFF);
    bus_read(2'd2, rd); check("blink_rst", rd, 32'd500);
    bus_read(2'd3, rd);
    check("status_phase_rst", {31'd0, rd[0]}, 32'd1);
    check("status_pend_rst", {31'd0, rd[16]}, 32'd0);
    avs_s0_address = 2'd3; #1;
    check("readdata_idle", avs_s0_readdata, 32'd0);
    repeat (20) step();

    for (int i = 0; i < 8; i++) begin
      bus_write(vecs[i].wr_addr, vecs[i].wdata);
      bus_read(vecs[i].rd_addr, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp_rd);
    end

    // BRIGHT=64 mid-period: old full duty until the wrap, then 64/256.
    align();
    repeat (100) step();
    bus_write(2'd1, 32'd64);
    bus_read(2'd3, rd); check("pend_after_write", {31'd0, rd[16]}, 32'd1);
    n = 256 - m_pwm;
    count_on(n, on);
    check("old_duty_holds", 32'(on), 32'(n));
    bus_read(2'd3, rd); check("pend_after_wrap", {31'd0, rd[16]}, 32'd0);
    for (int p = 0; p < 2; p++) begin
      count_on(64, on);  check("duty64_on", 32'(on), 32'd64);
      count_on(192, on); check("duty64_off", 32'(on), 32'd0);
    end

    // Duty extremes over three periods.
    bus_write(2'd1, 32'd0); align();
    count_on(768, on); check("duty0_on", 32'(on), 32'd0);
    bus_write(2'd1, 32'd255); align();
    count_on(768, on); check("duty255_on", 32'(on), 32'd768);

    // Blinking with a two-period half-period.
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'd3);
    repeat (1024) step();
    on = 0; toggles = 0;
    bus_read(2'd3, rd); prev = rd[0];
    for (int c = 0; c < 2048; c++) begin
      step();
      if (leds_out != 8'h00) on++;
      bus_read(2'd3, rd);
      if (rd[0] != prev) toggles++;
      prev = rd[0];
    end
    check("blink_on_cycles", 32'(on), 32'd1024);
    check("blink_toggles", 32'(toggles), 32'd4);
    bus_write(2'd2, 32'd0);
    step();
    bus_read(2'd3, rd); check("blink_off_phase", {31'd0, rd[0]}, 32'd1);

    // Disable while blinking: output drops one edge after the write.
    bus_write(2'd2, 32'd2);
    repeat (10) step();
    check("pre_disable_leds", {24'd0, leds_out}, 32'h0000_00A5);
    bus_write(2'd0, 32'd0);
    step();
    check("disable_leds", {24'd0, leds_out}, 32'd0);

    // Reset mid-period restores full duty and restarts the timebase.
    bus_write(2'd0, 32'd1);
    bus_write(2'd1, 32'd64); align();
    repeat (100) step();
    reset = 1'b1; step(); reset = 1'b0;
    bus_read(2'd3, rd); check("status_after_reset", rd, 32'h0000_0001);
    count_on(256, on); check("reset_full_duty", 32'(on), 32'd256);

    // Brightness curve at half scale.
    bus_write(2'd1, 32'd128); align();
    count_on(256, on);
`ifdef LED_PWM_GAMMA_EN
    check("half_scale_on", 32'(on), 32'd64);
`else
    check("half_scale_on", 32'(on), 32'd128);
`endif

    // Randomized traffic against the model.
    for (int r = 0; r < 4000; r++) begin
      logic [1:0] a;
      leds_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0: bus_write(a, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 3)));
          2'd2: bus_write(a, 32'($urandom_range(0, 3)));
          default: bus_write(a, $urandom);
        endcase
      end else if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
      end else begin
        step();
      end
      if ($urandom_range(0, 3) == 0) bus_read(2'($urandom_range(0, 3)), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
